multicycle_control: RTL

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5 cycles and drives datapath, memory and PC-update controls.
- Replaces the single-cycle opcode decoder for the shared-memory multi-cycle datapath.
- Adds `addi`, a memory ready/stall handshake, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register (opcode source) and the multi-cycle datapath/memory port.

---
 rtl/mc_ctrl_pkg.sv | 81 ++++++++
 rtl/multicycle_control_decode.sv | 68 ++++++
 rtl/multicycle_control.sv | 106 ++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode constants,
// the FSM state encoding, the encodings of the multi-bit datapath selects and
// the control vector produced by the per-state decoder.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    // Pure Moore control vector. ir_write is absent because it only ever
    // asserts as the mem_ready-qualified fetch write, formed in the parent.
    typedef struct packed {
        logic    pc_write;
        logic    pc_write_cond;
        logic    i_or_d;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_dst;
        logic    reg_write;
        logic    alu_src_a;
        src_b_t  alu_src_b;
        alu_op_t alu_op;
        pc_src_t pc_source;
        logic    illegal_op;
    } ctrl_t;

    // DECODE dispatch: the state that follows DECODE for a given opcode.
    function automatic state_t dispatch(input logic [5:0] op, input logic addi_en);
        state_t nxt;
        nxt = S_TRAP;
        case (op)
            OP_RTYPE:     nxt = S_EXEC;
            OP_LW, OP_SW: nxt = S_MEM_ADDR;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
            OP_ADDI:      nxt = addi_en ? S_ADDI_EXEC : S_TRAP;
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control-vector map for the multi-cycle control unit.
// Ports:
//   state_i : current FSM state
//   ctrl_o  : Moore control vector for that state (everything else 0)
module multicycle_control_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_TRAP: begin
                ctrl_o.illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing each instruction over
// 3-5 cycles (plus memory stall cycles), with an illegal-opcode trap and a
// retired-instruction counter.
// Ports:
//   clk, reset          : clock, async active-high reset
//   opcode              : IR[31:26], used in DECODE and MEM_ADDR only
//   mem_ready           : memory completes the current access this cycle
//   pc_write .. alu_src_a, alu_src_b, alu_op, pc_source : datapath controls
//   illegal_op          : high while parked in TRAP (until reset)
//   state               : current state encoding (debug)
//   instr_count         : retired-instruction count, wraps
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int   CNT_W   = 16,
    parameter logic ADDI_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              retire;
    logic              fetch_write;
    ctrl_t             ctrl;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = dispatch(opcode, ADDI_EN);
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC:      state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                         state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    // An instruction retires exactly when the FSM leaves a non-FETCH state
    // for FETCH; TRAP never does, so traps are not counted.
    assign retire  = (state_q != S_FETCH) && (state_d == S_FETCH);
    assign count_d = count_q + CNT_W'(retire);

    multicycle_control_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // Fetch-stage IR/PC writes follow mem_ready, and are suppressed during
    // reset so a held reset cannot corrupt IR or PC.
    assign fetch_write = (state_q == S_FETCH) && mem_ready && !reset;

    assign pc_write      = ctrl.pc_write | fetch_write;
    assign ir_write      = fetch_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;
    assign instr_count   = count_q;

endmodule
